// File: rtl/tsm_anf_accumulator_pkg.sv
// Shared definitions for the two-share ANF accumulator: FSM states,
// monomial bit positions and the monomial count.
package tsm_anf_accumulator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam int MONO_COUNT = 15;

    localparam int MONO_X    = 0;
    localparam int MONO_Y    = 1;
    localparam int MONO_Z    = 2;
    localparam int MONO_W    = 3;
    localparam int MONO_XY   = 4;
    localparam int MONO_XZ   = 5;
    localparam int MONO_XW   = 6;
    localparam int MONO_YZ   = 7;
    localparam int MONO_YW   = 8;
    localparam int MONO_ZW   = 9;
    localparam int MONO_XYZ  = 10;
    localparam int MONO_XYW  = 11;
    localparam int MONO_XZW  = 12;
    localparam int MONO_YZW  = 13;
    localparam int MONO_XYZW = 14;

    localparam int MONO_IDX [MONO_COUNT] = '{
        MONO_X, MONO_Y, MONO_Z, MONO_W,
        MONO_XY, MONO_XZ, MONO_XW, MONO_YZ, MONO_YW, MONO_ZW,
        MONO_XYZ, MONO_XYW, MONO_XZW, MONO_YZW, MONO_XYZW
    };

endpackage

// File: rtl/tsm_anf_partial.sv
// Combinational partial for one share: XOR of the monomial bits selected
// by the non-constant ANF coefficients. Works on a single share only.
module tsm_anf_partial
    import tsm_anf_accumulator_pkg::*;
(
    input  logic [MONO_COUNT-1:0] mono_vec,
    input  logic [MONO_COUNT-1:0] coeff_vec,
    output logic                  partial_bit
);

    // Fold every selected monomial of this share into one bit
    always_comb begin
        partial_bit = 1'b0;
        for (int i = 0; i < MONO_COUNT; i++) begin
            partial_bit = partial_bit ^ (coeff_vec[MONO_IDX[i]] & mono_vec[MONO_IDX[i]]);
        end
    end

endmodule

// File: rtl/tsm_anf_accumulator.sv
// Two-share threshold accumulator of an ANF function over NUM_STEPS beats.
// Each share is accumulated independently; the result is refreshed with
// one mask bit and held until the consumer takes it. The shares are never
// combined inside this block.
module tsm_anf_accumulator
    import tsm_anf_accumulator_pkg::*;
#(
    parameter int          NUM_STEPS = 2,
    parameter logic [15:0] ANF_COEFF = 16'h0103
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [14:0] mono_share1,
    input  logic [14:0] mono_share2,
    input  logic        rand_in,
    input  logic        clear,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        f_share1,
    output logic        f_share2,
    output logic        busy
);

    localparam int                CNT_W    = $clog2(NUM_STEPS) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_STEPS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             acc1, acc1_nxt;
    logic             acc2, acc2_nxt;
    logic             f1_nxt, f2_nxt;
    logic             out_valid_nxt;

    logic             partial1, partial2;
    logic             accept;
    logic             first_beat;
    logic             beat1, beat2;
    logic             new_acc1, new_acc2;
    logic [CNT_W-1:0] new_cnt;
    logic             last_beat;

    tsm_anf_partial u_partial_share1 (
        .mono_vec    (mono_share1),
        .coeff_vec   (ANF_COEFF[15:1]),
        .partial_bit (partial1)
    );

    tsm_anf_partial u_partial_share2 (
        .mono_vec    (mono_share2),
        .coeff_vec   (ANF_COEFF[15:1]),
        .partial_bit (partial2)
    );

    // Handshake: stall only while an unconsumed result is held; clear blocks intake
    assign in_ready = rst | (~clear & ((state != ST_HOLD) | out_ready));
    assign accept   = in_valid & in_ready;
    assign busy     = (state != ST_IDLE);

    // A beat taken in IDLE, or while releasing a held result, starts a new sum
    assign first_beat = (state == ST_IDLE) || (state == ST_HOLD);
    assign beat1      = partial1 ^ (ANF_COEFF[0] & first_beat);
    assign beat2      = partial2;
    assign new_acc1   = first_beat ? beat1 : (acc1 ^ beat1);
    assign new_acc2   = first_beat ? beat2 : (acc2 ^ beat2);
    assign new_cnt    = first_beat ? CNT_ONE : (cnt + CNT_ONE);
    assign last_beat  = (new_cnt == CNT_LAST);

    // Next-state logic: clear wins, then output release, then beat intake
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        acc1_nxt      = acc1;
        acc2_nxt      = acc2;
        f1_nxt        = f_share1;
        f2_nxt        = f_share2;
        out_valid_nxt = out_valid;

        if (clear) begin
            state_nxt     = ST_IDLE;
            cnt_nxt       = '0;
            acc1_nxt      = 1'b0;
            acc2_nxt      = 1'b0;
            out_valid_nxt = 1'b0;
        end else begin
            if ((state == ST_HOLD) && out_ready) begin
                state_nxt     = ST_IDLE;
                out_valid_nxt = 1'b0;
            end
            if (accept) begin
                acc1_nxt = new_acc1;
                acc2_nxt = new_acc2;
                cnt_nxt  = new_cnt;
                if (last_beat) begin
                    state_nxt     = ST_HOLD;
                    f1_nxt        = new_acc1 ^ rand_in;
                    f2_nxt        = new_acc2 ^ rand_in;
                    out_valid_nxt = 1'b1;
                end else begin
                    state_nxt = ST_ACCUM;
                end
            end
        end
    end

    // State, accumulators and registered output shares
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            acc1      <= 1'b0;
            acc2      <= 1'b0;
            out_valid <= 1'b0;
            f_share1  <= 1'b0;
            f_share2  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            acc1      <= acc1_nxt;
            acc2      <= acc2_nxt;
            out_valid <= out_valid_nxt;
            f_share1  <= f1_nxt;
            f_share2  <= f2_nxt;
        end
    end

endmodule

// File: tb/tb_tsm_anf_accumulator.sv
// Directed self-checking bench for tsm_anf_accumulator with the default
// function f = 1 ^ x ^ yz over two beats.
module tb_tsm_anf_accumulator;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] mono_share1;
    logic [14:0] mono_share2;
    logic        rand_in;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic        f_share1;
    logic        f_share2;
    logic        busy;

    int checkCount = 0;
    int passCount  = 0;

    tsm_anf_accumulator #(
        .NUM_STEPS (2),
        .ANF_COEFF (16'h0103)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mono_share1 (mono_share1),
        .mono_share2 (mono_share2),
        .rand_in     (rand_in),
        .clear       (clear),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .f_share1    (f_share1),
        .f_share2    (f_share2),
        .busy        (busy)
    );

    // Free-running clock, active edge at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and count it
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of input, advance past the active edge and drop in_valid
    task automatic applyStimulus(input logic valid, input logic [14:0] s1, input logic [14:0] s2, input logic r);
        in_valid    = valid;
        mono_share1 = s1;
        mono_share2 = s2;
        rand_in     = r;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Safety net so the run always ends
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected end before 50000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        mono_share1 = '0;
        mono_share2 = '0;
        rand_in     = 1'b0;
        clear       = 1'b0;
        out_ready   = 1'b0;

        // Reset state
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_f", {f_share1, f_share2}, 2'b00);
        #11;
        rst = 1'b0;

        // Single evaluation: f1=0, f2=1
        applyStimulus(1'b1, 15'h0001, 15'h0000, 1'b0);
        checkOutput("eval_beat1_busy", busy, 1);
        checkOutput("eval_beat1_no_valid", out_valid, 0);
        applyStimulus(1'b1, 15'h0000, 15'h0080, 1'b0);
        checkOutput("eval_out_valid", out_valid, 1);
        checkOutput("eval_f", {f_share1, f_share2}, 2'b01);

        // Backpressure: offered beats must be refused and outputs held
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 15'h7FFF, 15'h7FFF, 1'b1);
            checkOutput("bp_hold", {out_valid, in_ready, f_share1, f_share2}, 4'b1001);
        end
        out_ready = 1'b1;
        applyStimulus(1'b0, 15'h0000, 15'h0000, 1'b0);
        checkOutput("bp_release_valid", out_valid, 0);
        checkOutput("bp_release_busy", busy, 0);
        out_ready = 1'b0;

        // Mask refresh: rand_in=1 on final beat gives f1=1, f2=0
        applyStimulus(1'b1, 15'h0001, 15'h0000, 1'b0);
        applyStimulus(1'b1, 15'h0000, 15'h0080, 1'b1);
        checkOutput("mask_out_valid", out_valid, 1);
        checkOutput("mask_f", {f_share1, f_share2}, 2'b10);
        checkOutput("mask_xor", f_share1 ^ f_share2, 1);

        // Back-to-back: release and take a first beat in the same cycle
        out_ready = 1'b1;
        #1;
        checkOutput("b2b_in_ready", in_ready, 1);
        applyStimulus(1'b1, 15'h0000, 15'h0000, 1'b0);
        checkOutput("b2b_released", out_valid, 0);
        checkOutput("b2b_busy", busy, 1);
        out_ready = 1'b0;
        applyStimulus(1'b1, 15'h0080, 15'h0001, 1'b0);
        checkOutput("b2b_out_valid", out_valid, 1);
        checkOutput("b2b_f", {f_share1, f_share2}, 2'b01);
        out_ready = 1'b1;
        applyStimulus(1'b0, 15'h0000, 15'h0000, 1'b0);
        checkOutput("b2b_done", out_valid, 0);
        out_ready = 1'b0;

        // Clear after beat 1 of 2, offering a beat while clear is high
        applyStimulus(1'b1, 15'h0000, 15'h0001, 1'b0);
        clear       = 1'b1;
        in_valid    = 1'b1;
        mono_share1 = 15'h0001;
        mono_share2 = 15'h0080;
        #1;
        checkOutput("clr_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        checkOutput("clr_busy", busy, 0);
        checkOutput("clr_out_valid", out_valid, 0);
        applyStimulus(1'b1, 15'h0000, 15'h0000, 1'b0);
        checkOutput("clr_fresh1_no_valid", out_valid, 0);
        applyStimulus(1'b1, 15'h0000, 15'h0000, 1'b0);
        checkOutput("clr_out_valid2", out_valid, 1);
        checkOutput("clr_f", {f_share1, f_share2}, 2'b10);
        out_ready = 1'b1;
        applyStimulus(1'b0, 15'h0000, 15'h0000, 1'b0);
        out_ready = 1'b0;

        // Asynchronous reset mid-accumulation, no clock edge in between
        applyStimulus(1'b1, 15'h0001, 15'h0000, 1'b0);
        checkOutput("arst_pre_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_in_ready", in_ready, 1);
        checkOutput("arst_out_valid", out_valid, 0);
        checkOutput("arst_f", {f_share1, f_share2}, 2'b00);
        @(negedge clk);
        rst = 1'b0;

        // First beat after reset starts a fresh sum
        applyStimulus(1'b1, 15'h0000, 15'h0000, 1'b0);
        checkOutput("post_rst_no_valid", out_valid, 0);
        applyStimulus(1'b1, 15'h0000, 15'h0000, 1'b0);
        checkOutput("post_rst_out_valid", out_valid, 1);
        checkOutput("post_rst_f", {f_share1, f_share2}, 2'b10);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
